// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: one-hot FSM encodings,
// owner identifiers and the grant-selection helper.
package mem_arbiter_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE = 3'b001;
  localparam logic [STATE_W-1:0] S_REQ  = 3'b010;
  localparam logic [STATE_W-1:0] S_RSP  = 3'b100;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_MA = 1'b1;

  // On a tie, round-robin hands the grant to whichever port was not served last;
  // fixed priority always favours the memory-access stage.
  function automatic logic pick_owner(input logic pend_if,
                                      input logic pend_ma,
                                      input logic last,
                                      input logic rr_en);
    logic sel;
    if (pend_if && pend_ma) begin
      sel = rr_en ? ~last : OWN_MA;
    end else if (pend_ma) begin
      sel = OWN_MA;
    end else begin
      sel = OWN_IF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, memory-access port and shared memory channel
// seen by the arbiter; slave is the arbiter's view, master the environment's.
interface mem_arbiter_if;

  logic [31:0] IF_Addr;
  logic        IF_MemRead;
  logic        IF_Req_Ready;
  logic [31:0] IF_Read_data;
  logic        IF_Read_data_Valid;
  logic        IF_Read_data_Ready;

  logic [31:0] MA_Addr;
  logic        MA_MemRead;
  logic        MA_MemWrite;
  logic [31:0] MA_Write_data;
  logic [3:0]  MA_Write_strb;
  logic        MA_Req_Ready;
  logic [31:0] MA_Read_data;
  logic        MA_Read_data_Valid;
  logic        MA_Read_data_Ready;

  logic [31:0] Mem_Addr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  logic        Owner;

  modport slave (
    input  IF_Addr, IF_MemRead, IF_Read_data_Ready,
    output IF_Req_Ready, IF_Read_data, IF_Read_data_Valid,
    input  MA_Addr, MA_MemRead, MA_MemWrite, MA_Write_data, MA_Write_strb,
    input  MA_Read_data_Ready,
    output MA_Req_Ready, MA_Read_data, MA_Read_data_Valid,
    output Mem_Addr, MemRead, MemWrite, Write_data, Write_strb,
    input  Mem_Req_Ready,
    input  Read_data, Read_data_Valid,
    output Read_data_Ready,
    output Owner
  );

  modport master (
    output IF_Addr, IF_MemRead, IF_Read_data_Ready,
    input  IF_Req_Ready, IF_Read_data, IF_Read_data_Valid,
    output MA_Addr, MA_MemRead, MA_MemWrite, MA_Write_data, MA_Write_strb,
    output MA_Read_data_Ready,
    input  MA_Req_Ready, MA_Read_data, MA_Read_data_Valid,
    input  Mem_Addr, MemRead, MemWrite, Write_data, Write_strb,
    output Mem_Req_Ready,
    output Read_data, Read_data_Valid,
    input  Read_data_Ready,
    input  Owner
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and memory-access requests onto one memory port,
// keeping at most one transaction in flight (request phase, then read response).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  logic [STATE_W-1:0] state;
  logic               owner;
  logic               last;
  logic               is_write;

  logic pend_if;
  logic pend_ma;
  logic any_pend;
  logic sel;
  logic rsp_ready;

  assign pend_if  = bus.IF_MemRead;
  assign pend_ma  = bus.MA_MemRead | bus.MA_MemWrite;
  assign any_pend = pend_if | pend_ma;
  assign sel      = pick_owner(pend_if, pend_ma, last, RR_EN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      owner    <= OWN_IF;
      last     <= OWN_IF;
      is_write <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_pend) begin
            state    <= S_REQ;
            owner    <= sel;
            is_write <= (sel == OWN_MA) && bus.MA_MemWrite;
          end
        end
        S_REQ: begin
          if (bus.Mem_Req_Ready) begin
            last  <= owner;
            state <= is_write ? S_IDLE : S_RSP;
          end
        end
        S_RSP: begin
          if (bus.Read_data_Valid && rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the branches so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.Mem_Addr           = '0;
    bus.MemRead            = 1'b0;
    bus.MemWrite           = 1'b0;
    bus.Write_data         = '0;
    bus.Write_strb         = '0;
    bus.IF_Req_Ready       = 1'b0;
    bus.MA_Req_Ready       = 1'b0;
    bus.IF_Read_data       = '0;
    bus.IF_Read_data_Valid = 1'b0;
    bus.MA_Read_data       = '0;
    bus.MA_Read_data_Valid = 1'b0;
    rsp_ready              = 1'b0;

    if (state == S_REQ) begin
      if (owner == OWN_MA) begin
        bus.Mem_Addr     = bus.MA_Addr;
        bus.MemRead      = bus.MA_MemRead;
        bus.MemWrite     = bus.MA_MemWrite;
        bus.Write_data   = bus.MA_Write_data;
        bus.Write_strb   = bus.MA_Write_strb;
        bus.MA_Req_Ready = bus.Mem_Req_Ready;
      end else begin
        bus.Mem_Addr     = bus.IF_Addr;
        bus.MemRead      = bus.IF_MemRead;
        bus.IF_Req_Ready = bus.Mem_Req_Ready;
      end
    end

    // The response channel is steered to the owner only while a read is outstanding.
    if (state == S_RSP) begin
      if (owner == OWN_MA) begin
        rsp_ready              = bus.MA_Read_data_Ready;
        bus.MA_Read_data       = bus.Read_data;
        bus.MA_Read_data_Valid = bus.Read_data_Valid;
      end else begin
        rsp_ready              = bus.IF_Read_data_Ready;
        bus.IF_Read_data       = bus.Read_data;
        bus.IF_Read_data_Valid = bus.Read_data_Valid;
      end
    end
  end

  assign bus.Read_data_Ready = rsp_ready;
  assign bus.Owner           = owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: a round-robin instance is fully
// checked every cycle, a fixed-priority twin shares its stimulus for tie checks.
module tb_mem_arbiter;

  localparam logic [31:0] IF_ADDR  = 32'h0000_1000;
  localparam logic [31:0] MA_ADDR  = 32'h0000_2000;
  localparam logic [31:0] MA_WDATA = 32'hDEAD_BEEF;
  localparam logic [3:0]  MA_STRB  = 4'hF;

  typedef struct packed {
    logic        if_rd;
    logic        ma_rd;
    logic        ma_wr;
    logic        mrr;
    logic        rv;
    logic        if_dr;
    logic        ma_dr;
    logic [31:0] rdata;
  } in_t;

  typedef struct packed {
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        rd_ready;
    logic        if_rr;
    logic        ma_rr;
    logic        if_v;
    logic [31:0] if_d;
    logic        ma_v;
    logic [31:0] ma_d;
    logic        owner;
  } outs_t;

  typedef struct {
    string name;
    in_t   in;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_arbiter_if bus ();
  mem_arbiter_if bus0 ();

  mem_arbiter #(.RR_EN(1'b1)) dut    (.clk(clk), .rst(rst), .bus(bus.slave));
  mem_arbiter #(.RR_EN(1'b0)) dut_fx (.clk(clk), .rst(rst), .bus(bus0.slave));

  assign bus0.IF_Addr            = bus.IF_Addr;
  assign bus0.IF_MemRead         = bus.IF_MemRead;
  assign bus0.IF_Read_data_Ready = bus.IF_Read_data_Ready;
  assign bus0.MA_Addr            = bus.MA_Addr;
  assign bus0.MA_MemRead         = bus.MA_MemRead;
  assign bus0.MA_MemWrite        = bus.MA_MemWrite;
  assign bus0.MA_Write_data      = bus.MA_Write_data;
  assign bus0.MA_Write_strb      = bus.MA_Write_strb;
  assign bus0.MA_Read_data_Ready = bus.MA_Read_data_Ready;
  assign bus0.Mem_Req_Ready      = bus.Mem_Req_Ready;
  assign bus0.Read_data          = bus.Read_data;
  assign bus0.Read_data_Valid    = bus.Read_data_Valid;

  outs_t act_rr;
  outs_t act_fx;

  assign act_rr = {bus.Mem_Addr, bus.MemRead, bus.MemWrite, bus.Write_data, bus.Write_strb,
                   bus.Read_data_Ready, bus.IF_Req_Ready, bus.MA_Req_Ready,
                   bus.IF_Read_data_Valid, bus.IF_Read_data,
                   bus.MA_Read_data_Valid, bus.MA_Read_data, bus.Owner};
  assign act_fx = {bus0.Mem_Addr, bus0.MemRead, bus0.MemWrite, bus0.Write_data, bus0.Write_strb,
                   bus0.Read_data_Ready, bus0.IF_Req_Ready, bus0.MA_Req_Ready,
                   bus0.IF_Read_data_Valid, bus0.IF_Read_data,
                   bus0.MA_Read_data_Valid, bus0.MA_Read_data, bus0.Owner};

  always #5 clk = ~clk;

  int   n_vec  = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  function automatic in_t mk_in(logic if_rd, logic ma_rd, logic ma_wr, logic mrr,
                                logic rv, logic if_dr, logic ma_dr, logic [31:0] rdata);
    in_t v;
    v = '{if_rd: if_rd, ma_rd: ma_rd, ma_wr: ma_wr, mrr: mrr,
          rv: rv, if_dr: if_dr, ma_dr: ma_dr, rdata: rdata};
    return v;
  endfunction

  function automatic outs_t o_idle(logic own);
    outs_t o = '0;
    o.owner = own;
    return o;
  endfunction

  function automatic outs_t o_req_if(logic mrr);
    outs_t o = '0;
    o.mem_addr = IF_ADDR;
    o.mem_rd   = 1'b1;
    o.if_rr    = mrr;
    o.owner    = 1'b0;
    return o;
  endfunction

  function automatic outs_t o_req_ma(logic rd, logic wr, logic mrr);
    outs_t o = '0;
    o.mem_addr = MA_ADDR;
    o.mem_rd   = rd;
    o.mem_wr   = wr;
    o.wdata    = MA_WDATA;
    o.strb     = MA_STRB;
    o.ma_rr    = mrr;
    o.owner    = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_rsp(logic own, logic rdy, logic v, logic [31:0] d);
    outs_t o = '0;
    o.rd_ready = rdy;
    o.owner    = own;
    if (own) begin
      o.ma_v = v;
      o.ma_d = d;
    end else begin
      o.if_v = v;
      o.if_d = d;
    end
    return o;
  endfunction

  task automatic add(input string name, input in_t in, input outs_t exp);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic apply(input in_t v);
    bus.IF_MemRead         = v.if_rd;
    bus.MA_MemRead         = v.ma_rd;
    bus.MA_MemWrite        = v.ma_wr;
    bus.Mem_Req_Ready      = v.mrr;
    bus.Read_data_Valid    = v.rv;
    bus.IF_Read_data_Ready = v.if_dr;
    bus.MA_Read_data_Ready = v.ma_dr;
    bus.Read_data          = v.rdata;
  endtask

  task automatic check(input string name, input outs_t act, input outs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string name, input in_t in, input outs_t exp);
    @(negedge clk);
    apply(in);
    #1;
    check(name, act_rr, exp);
  endtask

  initial begin
    in_t zero;
    zero = '0;

    bus.IF_Addr       = IF_ADDR;
    bus.MA_Addr       = MA_ADDR;
    bus.MA_Write_data = MA_WDATA;
    bus.MA_Write_strb = MA_STRB;
    apply(zero);

    // Solo fetch read with two stalled request cycles.
    add("a_idle",   mk_in(1,0,0,0,0,0,0,0), o_idle(1'b0));
    add("a_wait1",  mk_in(1,0,0,0,0,0,0,0), o_req_if(1'b0));
    add("a_wait2",  mk_in(1,0,0,0,0,0,0,0), o_req_if(1'b0));
    add("a_accept", mk_in(1,0,0,1,0,0,0,0), o_req_if(1'b1));
    add("a_rsp_nv", mk_in(0,0,0,0,0,1,0,0), o_rsp(1'b0, 1'b1, 1'b0, 32'h0));
    add("a_rsp",    mk_in(0,0,0,0,1,1,0,32'h1234_5678), o_rsp(1'b0, 1'b1, 1'b1, 32'h1234_5678));
    add("a_done",   zero, o_idle(1'b0));
    // Fetch read racing a store: store first, then the fetch, once each.
    add("b_tie",    mk_in(1,0,1,0,0,0,0,0), o_idle(1'b0));
    add("b_ma_wr",  mk_in(1,0,1,1,0,0,0,0), o_req_ma(1'b0, 1'b1, 1'b1));
    add("b_if_idl", mk_in(1,0,0,0,0,0,0,0), o_idle(1'b1));
    add("b_if_req", mk_in(1,0,0,1,0,0,0,0), o_req_if(1'b1));
    add("b_if_rsp", mk_in(0,0,0,0,1,1,0,32'hCAFE_0001), o_rsp(1'b0, 1'b1, 1'b1, 32'hCAFE_0001));
    add("b_done1",  zero, o_idle(1'b0));
    add("b_done2",  zero, o_idle(1'b0));
    // Both ports reading continuously: grants alternate MA, IF, MA, IF.
    for (int k = 0; k < 2; k++) begin
      add($sformatf("c%0d_tie_ma", k), mk_in(1,1,0,0,0,0,0,0), o_idle(1'b0));
      add($sformatf("c%0d_ma_req", k), mk_in(1,1,0,1,0,0,0,0), o_req_ma(1'b1, 1'b0, 1'b1));
      add($sformatf("c%0d_ma_rsp", k), mk_in(1,1,0,0,1,0,1,32'hA0 + 32'(2*k)),
          o_rsp(1'b1, 1'b1, 1'b1, 32'hA0 + 32'(2*k)));
      add($sformatf("c%0d_tie_if", k), mk_in(1,1,0,0,0,0,0,0), o_idle(1'b1));
      add($sformatf("c%0d_if_req", k), mk_in(1,1,0,1,0,0,0,0), o_req_if(1'b1));
      add($sformatf("c%0d_if_rsp", k), mk_in(1,1,0,0,1,1,0,32'hA1 + 32'(2*k)),
          o_rsp(1'b0, 1'b1, 1'b1, 32'hA1 + 32'(2*k)));
    end
    // MA read response back-pressured for three cycles while IF waits.
    add("d_tie",    mk_in(1,1,0,0,0,0,0,0), o_idle(1'b0));
    add("d_ma_req", mk_in(1,1,0,1,0,0,0,0), o_req_ma(1'b1, 1'b0, 1'b1));
    for (int j = 0; j < 3; j++)
      add($sformatf("d_hold%0d", j), mk_in(1,0,0,1,1,0,0,32'hB0), o_rsp(1'b1, 1'b0, 1'b1, 32'hB0));
    add("d_ma_done", mk_in(1,0,0,1,1,0,1,32'hB0), o_rsp(1'b1, 1'b1, 1'b1, 32'hB0));
    add("d_if_idl",  mk_in(1,0,0,0,0,0,0,0), o_idle(1'b1));
    add("d_if_req",  mk_in(1,0,0,1,0,0,0,0), o_req_if(1'b1));
    add("d_if_rsp",  mk_in(0,0,0,0,1,1,0,32'hB1), o_rsp(1'b0, 1'b1, 1'b1, 32'hB1));
    add("d_done",    zero, o_idle(1'b0));

    // Reset state, including with requests and response valid driven.
    @(negedge clk);
    #1;
    check("rst_rr", act_rr, '0);
    check("rst_fx", act_fx, '0);
    apply(mk_in(1,1,0,1,1,1,1,32'hFFFF_FFFF));
    @(negedge clk);
    #1;
    check("rst_busy_rr", act_rr, '0);
    apply(zero);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i].in);
      #1;
      check(vecs[i].name, act_rr, vecs[i].exp);
    end

    // Reset asserted mid-response abandons the read; pending fetch is granted after release.
    step("r_idle", mk_in(1,0,0,0,0,0,0,0), o_idle(1'b0));
    step("r_req",  mk_in(1,0,0,1,0,0,0,0), o_req_if(1'b1));
    step("r_rsp",  mk_in(1,0,0,0,1,0,0,32'hD0), o_rsp(1'b0, 1'b0, 1'b1, 32'hD0));
    #2;
    rst = 1'b0;
    #1;
    check("r_async", act_rr, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("r_release", act_rr, o_idle(1'b0));
    step("r_grant",  mk_in(1,0,0,0,0,0,0,0), o_req_if(1'b0));
    step("r_accept", mk_in(1,0,0,1,0,0,0,0), o_req_if(1'b1));
    step("r_data",   mk_in(0,0,0,0,1,1,0,32'hD1), o_rsp(1'b0, 1'b1, 1'b1, 32'hD1));
    step("r_done",   zero, o_idle(1'b0));

    // Second tie after an MA grant: round-robin picks IF, fixed priority stays on MA.
    step("t_idle", mk_in(1,1,0,0,0,0,0,0), o_idle(1'b0));
    check("t_idle_fx", act_fx, o_idle(1'b0));
    step("t_ma", mk_in(1,1,0,1,0,0,0,0), o_req_ma(1'b1, 1'b0, 1'b1));
    check("t_ma_fx", act_fx, o_req_ma(1'b1, 1'b0, 1'b1));
    step("t_rsp", mk_in(1,1,0,0,1,1,1,32'hE0), o_rsp(1'b1, 1'b1, 1'b1, 32'hE0));
    check("t_rsp_fx", act_fx, o_rsp(1'b1, 1'b1, 1'b1, 32'hE0));
    step("t_idle2", mk_in(1,1,0,0,0,0,0,0), o_idle(1'b1));
    step("t_rr_if", mk_in(1,1,0,1,0,0,0,0), o_req_if(1'b1));
    check("t_fx_ma", act_fx, o_req_ma(1'b1, 1'b0, 1'b1));
    step("t_end", mk_in(0,0,0,0,1,1,1,32'hE1), o_rsp(1'b0, 1'b1, 1'b1, 32'hE1));
    check("t_end_fx", act_fx, o_rsp(1'b1, 1'b1, 1'b1, 32'hE1));
    step("t_done", zero, o_idle(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
